// File: rtl/game_pkg.sv
// Shared game definitions: slot geometry, recorder state encoding and the
// level-to-length decode used by the generator, player and recorder.
package game_pkg;

   localparam int NSLOT  = 16;
   localparam int SLOT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_PRESS,
      S_DEBOUNCE,
      S_WAIT_RELEASE,
      S_DONE
   } state_t;

   // One-hot level to pattern length; anything that is not one-hot gives 0.
   function automatic logic [4:0] lvl_to_len(input logic [2:0] level);
      case (level)
         3'b001:  lvl_to_len = 5'd8;
         3'b010:  lvl_to_len = 5'd12;
         3'b100:  lvl_to_len = 5'd16;
         default: lvl_to_len = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/button_sequence_recorder_if.sv
// Bundle of the recorder's control inputs and result outputs.
interface button_sequence_recorder_if;
   import game_pkg::*;

   logic                    start;
   logic [2:0]              level;
   logic [7:0]              botton;
   logic [NSLOT*SLOT_W-1:0] slot_data;
   logic [4:0]              count;
   logic [7:0]              echo_led;
   logic                    busy;
   logic                    done;
   logic                    timeout_flag;

   modport master (
      output start, level, botton,
      input  slot_data, count, echo_led, busy, done, timeout_flag
   );

   modport slave (
      input  start, level, botton,
      output slot_data, count, echo_led, busy, done, timeout_flag
   );

endinterface

// File: rtl/button_sequence_recorder_btn_sync.sv
// Two-flop synchronizer for the raw buttons followed by a priority encoder
// in which the lowest-numbered pressed button wins.
module btn_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] botton,
   output logic       any_high,
   output logic [2:0] index
);

   logic [7:0] meta;
   logic [7:0] sync;

   // Bring the asynchronous buttons into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= botton;
         sync <= meta;
      end
   end

   // Scan from the top so the lowest set bit is the one that sticks.
   always_comb begin
      any_high = |sync;
      index    = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (sync[i]) index = 3'(i);
      end
   end

endmodule

// File: rtl/button_sequence_recorder.sv
// Records a debounced sequence of button presses into a slot buffer whose
// length is chosen by the level, then holds done until the next round.
module button_sequence_recorder
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 20,
   parameter int TIMEOUT_CYC  = 5000
) (
   input logic                       clk,
   input logic                       rst,
   button_sequence_recorder_if.slave bus
);

   localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYC - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

   state_t            state, state_n;
   logic [15:0]       deb_cnt, deb_n;
   logic [15:0]       idle_cnt, idle_n;
   logic              any_high;
   logic [2:0]        index;
   logic [2:0]        cur_idx;
   logic [4:0]        target;
   logic [4:0]        count;
   logic [4:0]        start_len;
   logic [7:0]        echo_led;
   logic              timeout_flag;
   logic [SLOT_W-1:0] slots [NSLOT];
   logic              start_cap, latch_idx, write_slot, echo_clr, set_to;

   btn_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .botton   (bus.botton),
      .any_high (any_high),
      .index    (index)
   );

   assign start_len = lvl_to_len(bus.level);

   // State and the two cycle counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         deb_cnt  <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_n;
         deb_cnt  <= deb_n;
         idle_cnt <= idle_n;
      end
   end

   // Next state, counter updates and datapath strobes.
   always_comb begin
      state_n    = state;
      deb_n      = deb_cnt;
      idle_n     = idle_cnt;
      start_cap  = 1'b0;
      latch_idx  = 1'b0;
      write_slot = 1'b0;
      echo_clr   = 1'b0;
      set_to     = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.start && start_len != 5'd0) begin
               state_n   = S_ARM;
               deb_n     = '0;
               idle_n    = '0;
               start_cap = 1'b1;
            end
         end
         S_ARM: begin
            if (any_high) begin
               deb_n = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_n = S_WAIT_PRESS;
               deb_n   = '0;
               idle_n  = '0;
            end else begin
               deb_n = deb_cnt + 16'd1;
            end
         end
         S_WAIT_PRESS: begin
            if (any_high) begin
               state_n   = S_DEBOUNCE;
               latch_idx = 1'b1;
               deb_n     = 16'd1;
            end else if (idle_cnt == TO_LAST) begin
               state_n = S_DONE;
               set_to  = 1'b1;
            end else begin
               idle_n = idle_cnt + 16'd1;
            end
         end
         S_DEBOUNCE: begin
            if (!any_high || index != cur_idx) begin
               state_n = S_WAIT_PRESS;
               deb_n   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_n    = S_WAIT_RELEASE;
               deb_n      = '0;
               write_slot = (count != target);
            end else begin
               deb_n = deb_cnt + 16'd1;
            end
         end
         S_WAIT_RELEASE: begin
            if (any_high) begin
               deb_n = '0;
            end else if (deb_cnt == DEB_LAST) begin
               echo_clr = 1'b1;
               deb_n    = '0;
               if (count == target) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_WAIT_PRESS;
                  idle_n  = '0;
               end
            end else begin
               deb_n = deb_cnt + 16'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Slot buffer, count, echo LED and the timeout qualifier.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSLOT; k++) slots[k] <= '0;
         target       <= '0;
         count        <= '0;
         cur_idx      <= '0;
         echo_led     <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (start_cap) begin
            for (int k = 0; k < NSLOT; k++) slots[k] <= '0;
            target       <= start_len;
            count        <= '0;
            echo_led     <= '0;
            timeout_flag <= 1'b0;
         end
         if (latch_idx) cur_idx <= index;
         if (write_slot) begin
            slots[count[3:0]] <= cur_idx;
            count             <= count + 5'd1;
            echo_led          <= 8'b1 << cur_idx;
         end
         if (echo_clr) echo_led <= '0;
         if (set_to) timeout_flag <= 1'b1;
      end
   end

   for (genvar k = 0; k < NSLOT; k++) begin : g_pack
      assign bus.slot_data[k*SLOT_W +: SLOT_W] = slots[k];
   end

   assign bus.count        = count;
   assign bus.echo_led     = echo_led;
   assign bus.timeout_flag = timeout_flag;
   assign bus.done         = (state == S_DONE);
   assign bus.busy         = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_button_sequence_recorder.sv
// Directed bench for the button sequence recorder with a write scoreboard.
module tb_button_sequence_recorder;
   import game_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_q[$];
   int   prev_count = 0;
   int   mon_cur;
   int   mon_exp;
   int   a_exp[8] = '{2, 0, 7, 1, 1, 4, 6, 3};
   logic [7:0]  a_btn[8] = '{8'h04, 8'h01, 8'h80, 8'h02, 8'h02, 8'h10, 8'h40, 8'h08};
   logic [47:0] a_slots;
   logic [4:0]  cnt_before;

   button_sequence_recorder_if bus();

   button_sequence_recorder #(
      .DEBOUNCE_CYC (4),
      .TIMEOUT_CYC  (50)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [2:0] lvl);
      bus.level = lvl;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic press(input logic [7:0] mask, input int hold, input int gap, input int exp_idx);
      exp_q.push_back(exp_idx);
      bus.botton = mask;
      repeat (hold) @(negedge clk);
      bus.botton = '0;
      repeat (gap) @(negedge clk);
   endtask

   // Every new slot write is matched against the oldest expected index.
   always @(negedge clk) begin
      mon_cur = int'(bus.count);
      if (mon_cur == prev_count + 1) begin
         n_cmp++;
         assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL sb_unexpected_write: observed slot %0d written expected no write", prev_count);
         end
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("sb_slot_value", 48'(bus.slot_data[prev_count*3 +: 3]), 48'(mon_exp));
         end
      end else if (mon_cur > prev_count) begin
         n_cmp++;
         assert (mon_cur == prev_count + 1) else begin
            n_err++;
            $error("FAIL sb_count_step: observed %0d expected %0d", mon_cur, prev_count + 1);
         end
      end
      prev_count = mon_cur;
   end

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.level  = 3'b000;
      bus.botton = '0;
      a_slots    = '0;
      for (int k = 0; k < 8; k++) a_slots[k*3 +: 3] = 3'(a_exp[k]);
      repeat (2) @(negedge clk);

      check("rst_slot_data", bus.slot_data, 48'd0);
      check("rst_count", 48'(bus.count), 48'd0);
      check("rst_echo", 48'(bus.echo_led), 48'd0);
      check("rst_busy", 48'(bus.busy), 48'd0);
      check("rst_done", 48'(bus.done), 48'd0);
      check("rst_timeout", 48'(bus.timeout_flag), 48'd0);
      rst = 1'b0;
      @(negedge clk);

      // Round A: level 001, eight clean presses.
      pulse_start(3'b001);
      check("a_busy_after_start", 48'(bus.busy), 48'd1);
      repeat (6) @(negedge clk);
      for (int k = 0; k < 8; k++) press(a_btn[k], 6, 6, a_exp[k]);
      repeat (2) @(negedge clk);
      check("a_done", 48'(bus.done), 48'd1);
      check("a_timeout", 48'(bus.timeout_flag), 48'd0);
      check("a_busy", 48'(bus.busy), 48'd0);
      check("a_count", 48'(bus.count), 48'd8);
      check("a_echo", 48'(bus.echo_led), 48'd0);
      check("a_slot_data", bus.slot_data, a_slots);
      check("a_upper_slots", 48'(bus.slot_data[47:24]), 48'd0);
      check("a_sb_empty", 48'(exp_q.size()), 48'd0);

      // Round B: button held through a re-start from DONE.
      bus.botton = 8'h08;
      @(negedge clk);
      pulse_start(3'b010);
      check("b_restart_clear", bus.slot_data, 48'd0);
      check("b_restart_count", 48'(bus.count), 48'd0);
      check("b_restart_done", 48'(bus.done), 48'd0);
      check("b_restart_busy", 48'(bus.busy), 48'd1);
      repeat (10) @(negedge clk);
      check("b_held_no_write", 48'(bus.count), 48'd0);
      check("b_held_no_echo", 48'(bus.echo_led), 48'd0);
      bus.botton = '0;
      repeat (6) @(negedge clk);
      press(8'h08, 6, 6, 3);
      check("b_repress_count", 48'(bus.count), 48'd1);

      // Glitch on button 5 then a clean hold on button 6.
      cnt_before = bus.count;
      bus.botton = 8'h10;
      repeat (2) @(negedge clk);
      press(8'h20, 6, 6, 5);
      check("b_glitch_count", 48'(bus.count), 48'(cnt_before + 5'd1));

      // Buttons 2 and 7 together.
      exp_q.push_back(1);
      bus.botton = 8'h42;
      repeat (8) @(negedge clk);
      check("b_dual_echo_held", 48'(bus.echo_led), 48'h02);
      check("b_dual_count", 48'(bus.count), 48'd3);
      bus.botton = '0;
      check("b_dual_echo_release", 48'(bus.echo_led), 48'h02);
      repeat (8) @(negedge clk);
      check("b_echo_cleared", 48'(bus.echo_led), 48'd0);
      check("b_still_busy", 48'(bus.busy), 48'd1);

      // A start while busy is ignored.
      pulse_start(3'b001);
      check("b_start_busy_ignored", 48'(bus.busy), 48'd1);
      check("b_start_count_kept", 48'(bus.count), 48'd3);
      check("b_start_done_low", 48'(bus.done), 48'd0);

      // Reset mid-capture.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("b_rst_slot_data", bus.slot_data, 48'd0);
      check("b_rst_count", 48'(bus.count), 48'd0);
      check("b_rst_busy", 48'(bus.busy), 48'd0);
      check("b_rst_done", 48'(bus.done), 48'd0);
      check("b_sb_empty", 48'(exp_q.size()), 48'd0);

      // Round C: invalid level.
      pulse_start(3'b011);
      repeat (3) @(negedge clk);
      check("c_invalid_busy", 48'(bus.busy), 48'd0);
      check("c_invalid_done", 48'(bus.done), 48'd0);

      // Round D: level 100 timeout, 4 ARM cycles plus 50 idle cycles.
      pulse_start(3'b100);
      repeat (53) @(negedge clk);
      check("d_done_not_early", 48'(bus.done), 48'd0);
      check("d_busy_before", 48'(bus.busy), 48'd1);
      @(negedge clk);
      check("d_done", 48'(bus.done), 48'd1);
      check("d_timeout_flag", 48'(bus.timeout_flag), 48'd1);
      check("d_count", 48'(bus.count), 48'd0);
      check("d_busy", 48'(bus.busy), 48'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/button_sequence_recorder.md
# button_sequence_recorder

Receive-side counterpart of the LED pattern player. It captures the player's button presses after a pattern has been shown, debounces them and encodes each press as a 3-bit button index. It stores the indices in a 16-slot buffer sized by the selected level, then raises a held completion flag for the round-win comparator and the round/score logic.

## Interface
Parameters:
- DEBOUNCE_CYC, default 20: consecutive stable cycles required for a press or release (20 ms at the 1 kHz clock).
- TIMEOUT_CYC, default 5000: idle cycles in WAIT_PRESS before the round is abandoned (5 s at 1 kHz).

Ports (single clock; reset is synchronous and active-high):
- clk  in  1  1 kHz game clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a capture.
- level  in  3  one-hot level: 001 → 8 slots, 010 → 12 slots, 100 → 16 slots.
- botton  in  8  raw, asynchronous buttons; bit i is button i+1.
- slot_data  out  48  16 × 3-bit indices; slot k occupies [3k+2:3k]; each value is 0..7.
- count  out  5  number of slots written so far.
- echo_led  out  8  one-hot LED of the accepted button while it is held.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  held high from capture end until rst or the next accepted start.
- timeout_flag  out  1  qualifies done: the capture ended by timeout.

## Operation
- Buttons pass through a 2-flop synchronizer. State logic sees only synchronized values.
- If more than one button is high, the lowest index wins.
- States:
  - IDLE: a start with a valid one-hot level latches target = 8, 12 or 16, clears count, slot_data and both flags, and moves to ARM. A start with an invalid level is ignored.
  - ARM: waits until all buttons have been low for DEBOUNCE_CYC cycles, so a button held from the previous round is rejected. Then moves to WAIT_PRESS.
  - WAIT_PRESS: any button high moves to DEBOUNCE and latches the index. The idle counter increments each cycle here; when it reaches TIMEOUT_CYC the block moves to DONE with timeout_flag=1.
  - DEBOUNCE: the same button must stay high for DEBOUNCE_CYC cycles. Any change returns to WAIT_PRESS without writing. On success, slot[count] ← index, count++, echo_led ← one-hot(index), then WAIT_RELEASE.
  - WAIT_RELEASE: all buttons must be low for DEBOUNCE_CYC cycles. Then echo_led clears. If count == target the block moves to DONE; otherwise it returns to WAIT_PRESS and clears the idle counter.
  - DONE: done=1. Outputs are frozen. A valid start re-enters ARM, clearing the buffer.
- A start while busy is ignored.
- Slots at or beyond target stay 0, which matches the comparator's masked pattern.
- count saturates at target and never wraps. No write occurs when count == target.

## Timing
- Reset: state IDLE; slot_data, count, echo_led, busy, done, timeout_flag all 0; every internal counter 0.
- A rst asserted mid-capture discards the capture and applies the reset values on the next edge.
- start at edge t → busy=1 at t+1.
- A button first high at the synchronizer output at edge p → slot written, count incremented and echo_led set at edge p+DEBOUNCE_CYC.
- For the final slot, all buttons low at the synchronizer output from edge r → echo_led=0 and done=1 at edge r+DEBOUNCE_CYC; busy=0 at the same edge.
- Timeout: done and timeout_flag rise together at edge TIMEOUT_CYC after WAIT_PRESS is entered.
- If a press is first seen on the same cycle the timeout would fire, the press wins.
- done is a level, not a pulse. Consumers sample slot_data any time done=1.

## Structure
- Shared package `game_pkg`:
  - NSLOT=16 and SLOT_W=3.
  - State enum.
  - Function lvl_to_len(level) → 0 for invalid, otherwise 8, 12 or 16. This is shared with the pattern generator and the pattern player.
- Sub-module `btn_sync`: 8-bit 2-flop synchronizer plus lowest-index priority encoder. Outputs any_high and index[2:0].
- Top: FSM, debounce counter, idle/timeout counter, slot register file.

## Test plan
Bench uses DEBOUNCE_CYC=4, TIMEOUT_CYC=50.
- Level 001; buttons 3,1,8,2,2,5,7,4, each held 6 cycles with 6-cycle gaps → done=1, timeout_flag=0, count=8, slots 0..7 = 2,0,7,1,1,4,6,3, slots 8..15 = 0.
- A glitch of 2 cycles on button 5 followed by a clean hold on button 6 → only index 5 is written; count increments once.
- Buttons 2 and 7 pressed together → index 1 written; echo_led=0000_0010 until release.
- Level 100 with no presses after ARM → done=1 and timeout_flag=1 exactly 50 cycles after WAIT_PRESS entry; count=0.
- start with level=011 → stays IDLE, busy=0. A second start during capture → no effect. rst asserted after 3 slots → all outputs 0 next edge.
- Button held through start → no write until the button is released for 4 cycles and pressed again; a re-start after done clears slot_data to 0.
